// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock parametrised FIFO with fill level, programmable almost-full /
// almost-empty thresholds, synchronous flush and optional first-word-fall-
// through output.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   -> data_out is driven combinationally from the head entry and is
//                valid whenever empty is low (first-word-fall-through).
//   undefined -> data_out is registered, updated one cycle after an accepted
//                read and held otherwise.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush, overrides w_en / r_en
//   w_en, r_en   write / read requests
//   data_in      write data
//   data_out     read data
//   full, empty  occupancy == DEPTH / == 0
//   almost_full  level >= AF_LEVEL
//   almost_empty level <= AE_LEVEL
//   level        occupancy 0..DEPTH
//   write_error  one-cycle pulse after a write was rejected because full
//   read_error   one-cycle pulse after a read was rejected because empty
// -----------------------------------------------------------------------------
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int PTR_WIDTH  = 8,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    level,
    output logic                  write_error,
    output logic                  read_error
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Elaboration-time parameter sanity checks.
    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_flex: DEPTH must be a power of 2 and at least 4");
        end
        if ((1 << PTR_WIDTH) != DEPTH) begin : g_bad_ptr
            $error("sync_fifo_flex: PTR_WIDTH must equal log2(DEPTH)");
        end
        if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sync_fifo_flex: AF_LEVEL outside 0..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
            $error("sync_fifo_flex: AE_LEVEL outside 0..DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wptr_reg, wptr_next;
    logic [CW-1:0] rptr_reg, rptr_next;
    logic [CW-1:0] level_reg, level_next;
    logic          full_reg, full_next;
    logic          empty_reg, empty_next;
    logic          af_reg, af_next;
    logic          ae_reg, ae_next;
    logic          werr_reg, werr_next;
    logic          rerr_reg, rerr_next;
    logic          w_acc, r_acc;

    // Acceptance uses the registered flags; clr suppresses both requests.
    always_comb begin
        w_acc      = w_en && !full_reg  && !clr;
        r_acc      = r_en && !empty_reg && !clr;
        wptr_next  = clr ? '0 : wptr_reg + CW'(w_acc);
        rptr_next  = clr ? '0 : rptr_reg + CW'(r_acc);
        // Modulo-2^CW difference stays correct across any number of wraps.
        level_next = wptr_next - rptr_next;
        full_next  = (level_next == DEPTH_C);
        empty_next = (level_next == '0);
        af_next    = (level_next >= AF_C);
        ae_next    = (level_next <= AE_C);
        werr_next  = !clr && w_en && full_reg;
        rerr_next  = !clr && r_en && empty_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            af_reg    <= 1'b0;
            ae_reg    <= 1'b1;
            werr_reg  <= 1'b0;
            rerr_reg  <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            level_reg <= level_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
            af_reg    <= af_next;
            ae_reg    <= ae_next;
            werr_reg  <= werr_next;
            rerr_reg  <= rerr_next;
        end
    end

    // Storage is not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem[wptr_reg[PTR_WIDTH-1:0]] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry falls through; meaningful only while empty is low.
    assign data_out = mem[rptr_reg[PTR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] dout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg <= '0;
        end else if (clr) begin
            dout_reg <= '0;
        end else if (r_acc) begin
            dout_reg <= mem[rptr_reg[PTR_WIDTH-1:0]];
        end
    end

    assign data_out = dout_reg;
`endif

    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;
    assign level        = level_reg;
    assign write_error  = werr_reg;
    assign read_error   = rerr_reg;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Directed bench for sync_fifo_flex (DEPTH=16, DATA_WIDTH=8, AF=12, AE=4).
// A queue-based occupancy model predicts every output; a compare process
// checks the DUT against it on each falling edge, and literal checks in the
// stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int PW  = 4;
    localparam int AF  = 12;
    localparam int AE  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty;
    logic [PW:0]   level;
    logic          write_error, read_error;

    sync_fifo_flex #(
        .DATA_WIDTH(DW), .DEPTH(DEP), .PTR_WIDTH(PW),
        .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .r_en(r_en),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .write_error(write_error), .read_error(read_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // Model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_werr = 1'b0;
    bit            m_rerr = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, update model at the edge, return at the
    // following falling edge with outputs settled.
    task automatic cyc(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        int sz;
        w_en = w; r_en = r; clr = c; data_in = d;
        @(posedge clk);
        sz = q.size();
        if (c) begin
            q.delete();
            m_dout = '0;
            m_werr = 1'b0;
            m_rerr = 1'b0;
        end else begin
            m_werr = w && (sz == DEP);
            m_rerr = r && (sz == 0);
            if (r && sz > 0) m_dout = q.pop_front();
            if (w && sz < DEP) q.push_back(d);
        end
        @(negedge clk);
        $display("cyc w=%0d r=%0d clr=%0d din=0x%02h -> level=%0d dout=0x%02h full=%0d empty=%0d werr=%0d rerr=%0d",
                 w, r, c, d, level, data_out, full, empty, write_error, read_error);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("level", int'(level), q.size());
            chk("full", int'(full), int'(q.size() == DEP));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("almost_full", int'(almost_full), int'(q.size() >= AF));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
            chk("write_error", int'(write_error), int'(m_werr));
            chk("read_error", int'(read_error), int'(m_rerr));
`ifdef SYNC_FIFO_FWFT_EN
            if (q.size() > 0) chk("data_out", int'(data_out), int'(q[0]));
`else
            chk("data_out", int'(data_out), int'(m_dout));
`endif
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_errs", int'({write_error, read_error}), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_dout", int'(data_out), 0);
`endif
        rst_n = 1'b1;
        checking = 1'b1;

        // 1: fill 0x00..0x0F then drain
        for (int i = 0; i < DEP; i++) begin
            cyc(1, 0, 0, DW'(i));
            chk("t1_level", int'(level), i + 1);
            chk("t1_ae", int'(almost_empty), int'(i + 1 <= 4));
            chk("t1_af", int'(almost_full), int'(i + 1 >= 12));
        end
        chk("t1_full", int'(full), 1);
        for (int i = 0; i < DEP; i++) begin
            cyc(0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t1_dout", int'(data_out), i);
`endif
        end
        chk("t1_empty", int'(empty), 1);

        // 3: read while empty with simultaneous write of 0x55
        cyc(1, 1, 0, 8'h55);
        chk("t3_rerr", int'(read_error), 1);
        chk("t3_level", int'(level), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t3_dout_held", int'(data_out), 8'h0F);
`else
        chk("t3_fwft_dout", int'(data_out), 8'h55);
`endif
        cyc(0, 0, 0, 8'h00);
        chk("t3_rerr_pulse", int'(read_error), 0);
        cyc(0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t3_dout", int'(data_out), 8'h55);
`endif

        // 2: write while full
        for (int i = 0; i < DEP; i++) cyc(1, 0, 0, DW'(8'h20 + i));
        cyc(1, 0, 0, 8'hAA);
        chk("t2_werr", int'(write_error), 1);
        chk("t2_level", int'(level), 16);
        cyc(0, 0, 0, 8'h00);
        chk("t2_werr_pulse", int'(write_error), 0);
        for (int i = 0; i < DEP; i++) begin
            cyc(0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t2_dout", int'(data_out), 8'h20 + i);
`endif
        end

        // 5: flush together with a write
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, DW'(8'h40 + i));
        cyc(1, 0, 1, 8'h77);
        chk("t5_level", int'(level), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_werr", int'(write_error), 0);
        cyc(1, 0, 0, 8'h3C);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t5_fwft_dout", int'(data_out), 8'h3C);
`endif
        cyc(0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t5_dout", int'(data_out), 8'h3C);
`endif

        // 4: steady level 8 with simultaneous traffic, pointers wrap
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, DW'(i));
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, 0, DW'(8 + k));
            chk("t4_level", int'(level), 8);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t4_dout", int'(data_out), k);
`endif
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t4_drain", int'(data_out), 40 + i);
`endif
        end

`ifdef SYNC_FIFO_FWFT_EN
        // 6: first-word-fall-through
        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h11);
        chk("t6_empty", int'(empty), 0);
        chk("t6_dout0", int'(data_out), 8'h11);
        cyc(1, 0, 0, 8'h22);
        chk("t6_level2", int'(level), 2);
        cyc(0, 1, 0, 8'h00);
        chk("t6_level1", int'(level), 1);
        chk("t6_dout1", int'(data_out), 8'h22);
`endif

        cyc(0, 0, 0, 8'h00);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
